// File: rtl/zion_riscv_add_sub_issue_pipe.sv
// Two-stage valid/ready issue pipe (S1 issue, S2 result) wrapped around the combinational add/sub executor.
// Optional zero-latency bypass when both stages are empty: define ZION_ADDSUB_ISSUE_PIPE_BYPASS_EN.
module zion_riscv_add_sub_issue_pipe #(
  parameter  int RV64      = 0,
  localparam int CPU_WIDTH = 32 * (RV64 + 1),
  localparam int OP_W      = RV64 + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [OP_W-1:0]      in_op_i,
  input  logic [CPU_WIDTH-1:0] in_s1_i,
  input  logic [CPU_WIDTH-1:0] in_s2_i,
  input  logic [4:0]           in_rd_i,
  input  logic                 in_cmp_unsigned_i,
  output logic [OP_W-1:0]      ex_op_o,
  output logic [CPU_WIDTH-1:0] ex_s1_o,
  output logic [CPU_WIDTH-1:0] ex_s2_o,
  input  logic [CPU_WIDTH-1:0] ex_rslt_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CPU_WIDTH-1:0] out_rslt_o,
  output logic                 out_lt_o,
  output logic [4:0]           out_rd_o
);

  localparam int MSB = CPU_WIDTH - 1;

  logic                 s1Valid_q, s1Valid_d;
  logic [OP_W-1:0]      s1Op_q, s1Op_d;
  logic [CPU_WIDTH-1:0] s1Src1_q, s1Src1_d;
  logic [CPU_WIDTH-1:0] s1Src2_q, s1Src2_d;
  logic [4:0]           s1Rd_q, s1Rd_d;
  logic                 s1Cmpu_q, s1Cmpu_d;

  logic                 s2Valid_q, s2Valid_d;
  logic [CPU_WIDTH-1:0] s2Rslt_q, s2Rslt_d;
  logic                 s2Lt_q, s2Lt_d;
  logic [4:0]           s2Rd_q, s2Rd_d;

  logic s2Adv;
  logic s2Load;
  logic inReady;
  logic inLoad;
  logic s1Lt;

  assign s2Adv   = s1Valid_q & (~s2Valid_q | out_ready_i);
  assign s2Load  = s2Adv & ~flush_i;
  assign inReady = ~s1Valid_q | s2Adv;
  assign in_ready_o = inReady;

  // Operands of differing sign under an unsigned compare: the larger is the one with MSB set.
  assign s1Lt = (s1Cmpu_q & (s1Src1_q[MSB] ^ s1Src2_q[MSB])) ? s1Src2_q[MSB] : ex_rslt_i[MSB];

`ifdef ZION_ADDSUB_ISSUE_PIPE_BYPASS_EN
  logic bypass;
  logic bypassLt;

  assign bypass   = ~s1Valid_q & ~s2Valid_q & out_ready_i;
  assign inLoad   = in_valid_i & inReady & ~bypass & ~flush_i;
  assign bypassLt = (in_cmp_unsigned_i & (in_s1_i[MSB] ^ in_s2_i[MSB])) ? in_s2_i[MSB]
                                                                         : ex_rslt_i[MSB];

  always_comb begin
    if (bypass) begin
      ex_op_o     = in_valid_i ? in_op_i : '0;
      ex_s1_o     = in_s1_i;
      ex_s2_o     = in_s2_i;
      out_valid_o = in_valid_i & ~flush_i;
      out_rslt_o  = ex_rslt_i;
      out_lt_o    = bypassLt;
      out_rd_o    = in_rd_i;
    end else begin
      ex_op_o     = s1Valid_q ? s1Op_q : '0;
      ex_s1_o     = s1Src1_q;
      ex_s2_o     = s1Src2_q;
      out_valid_o = s2Valid_q;
      out_rslt_o  = s2Rslt_q;
      out_lt_o    = s2Lt_q;
      out_rd_o    = s2Rd_q;
    end
  end
`else
  assign inLoad = in_valid_i & inReady & ~flush_i;

  always_comb begin
    ex_op_o     = s1Valid_q ? s1Op_q : '0;
    ex_s1_o     = s1Src1_q;
    ex_s2_o     = s1Src2_q;
    out_valid_o = s2Valid_q;
    out_rslt_o  = s2Rslt_q;
    out_lt_o    = s2Lt_q;
    out_rd_o    = s2Rd_q;
  end
`endif

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Op_d    = s1Op_q;
    s1Src1_d  = s1Src1_q;
    s1Src2_d  = s1Src2_q;
    s1Rd_d    = s1Rd_q;
    s1Cmpu_d  = s1Cmpu_q;
    s2Valid_d = s2Valid_q;
    s2Rslt_d  = s2Rslt_q;
    s2Lt_d    = s2Lt_q;
    s2Rd_d    = s2Rd_q;

    if (inLoad) begin
      s1Valid_d = 1'b1;
      s1Op_d    = in_op_i;
      s1Src1_d  = in_s1_i;
      s1Src2_d  = in_s2_i;
      s1Rd_d    = in_rd_i;
      s1Cmpu_d  = in_cmp_unsigned_i;
    end else if (s2Adv) begin
      s1Valid_d = 1'b0;
    end

    if (s2Load) begin
      s2Valid_d = 1'b1;
      s2Rslt_d  = ex_rslt_i;
      s2Lt_d    = s1Lt;
      s2Rd_d    = s1Rd_q;
    end else if (s2Valid_q & out_ready_i) begin
      s2Valid_d = 1'b0;
    end

    // Flush wins over loads; an output handshake in this cycle still counts as consumed.
    if (flush_i) begin
      s1Valid_d = 1'b0;
      s2Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= '0;
      s1Src1_q  <= '0;
      s1Src2_q  <= '0;
      s1Rd_q    <= '0;
      s1Cmpu_q  <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Rslt_q  <= '0;
      s2Lt_q    <= 1'b0;
      s2Rd_q    <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1Src1_q  <= s1Src1_d;
      s1Src2_q  <= s1Src2_d;
      s1Rd_q    <= s1Rd_d;
      s1Cmpu_q  <= s1Cmpu_d;
      s2Valid_q <= s2Valid_d;
      s2Rslt_q  <= s2Rslt_d;
      s2Lt_q    <= s2Lt_d;
      s2Rd_q    <= s2Rd_d;
    end
  end

`ifndef SYNTHESIS
  illegalAddSubOp: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i & in_ready_o) |-> !(in_op_i[0] & in_op_i[1]));
`endif

endmodule

// File: tb/tb_zion_riscv_add_sub_issue_pipe.sv
// Scoreboard bench for zion_riscv_add_sub_issue_pipe: DUT A is RV64=0, DUT B is RV64=1, each fed by a model executor.
module tb_zion_riscv_add_sub_issue_pipe;

  typedef struct {
    logic [63:0] rslt;
    logic        lt;
    logic [4:0]  rd;
  } expT;

  logic clk, rst, flush, outReady;

  logic        inValidA, inReadyA, inCmpuA, outValidA, outLtA;
  logic [1:0]  inOpA, exOpA;
  logic [31:0] inS1A, inS2A, exS1A, exS2A, exRsltA, outRsltA;
  logic [4:0]  inRdA, outRdA;

  logic        inValidB, inReadyB, inCmpuB, outValidB, outLtB;
  logic [2:0]  inOpB, exOpB;
  logic [63:0] inS1B, inS2B, exS1B, exS2B, exRsltB, outRsltB;
  logic [4:0]  inRdB, outRdB;
  logic [31:0] wordB;

  expT qA[$];
  expT qB[$];
  int  checks = 0;
  int  failures = 0;

  zion_riscv_add_sub_issue_pipe #(.RV64(0)) dutA (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inValidA), .in_ready_o(inReadyA), .in_op_i(inOpA),
    .in_s1_i(inS1A), .in_s2_i(inS2A), .in_rd_i(inRdA), .in_cmp_unsigned_i(inCmpuA),
    .ex_op_o(exOpA), .ex_s1_o(exS1A), .ex_s2_o(exS2A), .ex_rslt_i(exRsltA),
    .out_valid_o(outValidA), .out_ready_i(outReady),
    .out_rslt_o(outRsltA), .out_lt_o(outLtA), .out_rd_o(outRdA)
  );

  zion_riscv_add_sub_issue_pipe #(.RV64(1)) dutB (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inValidB), .in_ready_o(inReadyB), .in_op_i(inOpB),
    .in_s1_i(inS1B), .in_s2_i(inS2B), .in_rd_i(inRdB), .in_cmp_unsigned_i(inCmpuB),
    .ex_op_o(exOpB), .ex_s1_o(exS1B), .ex_s2_o(exS2B), .ex_rslt_i(exRsltB),
    .out_valid_o(outValidB), .out_ready_i(outReady),
    .out_rslt_o(outRsltB), .out_lt_o(outLtB), .out_rd_o(outRdB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural executors standing in for the real add/sub unit.
  always_comb begin
    exRsltA = exOpA[0] ? exS1A + exS2A : (exOpA[1] ? exS1A - exS2A : 32'h0);
  end

  always_comb begin
    wordB = exOpB[0] ? exS1B[31:0] + exS2B[31:0] : (exOpB[1] ? exS1B[31:0] - exS2B[31:0] : 32'h0);
    if (exOpB[2]) exRsltB = {{32{wordB[31]}}, wordB};
    else          exRsltB = exOpB[0] ? exS1B + exS2B : (exOpB[1] ? exS1B - exS2B : 64'h0);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request and pushes its expected response once the handshake edge has passed.
  task automatic applyStimulus(input int which, input logic [2:0] op, input logic [63:0] s1,
                               input logic [63:0] s2, input logic [4:0] rd, input logic cmpu,
                               input logic [63:0] expRslt, input logic expLt);
    expT e;
    bit accepted = 0;
    e.rslt = expRslt;
    e.lt   = expLt;
    e.rd   = rd;
    if (which == 0) begin
      inValidA = 1'b1; inOpA = op[1:0]; inS1A = s1[31:0]; inS2A = s2[31:0];
      inRdA = rd; inCmpuA = cmpu;
    end else begin
      inValidB = 1'b1; inOpB = op; inS1B = s1; inS2B = s2; inRdB = rd; inCmpuB = cmpu;
    end
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      accepted = (which == 0) ? inReadyA : inReadyB;
      @(posedge clk);
      #1;
    end
    if (accepted) begin
      if (which == 0) qA.push_back(e);
      else            qB.push_back(e);
    end else begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end
    inValidA = 1'b0;
    inValidB = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && (qA.size() + qB.size()) != 0; i++) @(posedge clk);
    #1;
    checkOutput(name, 64'(qA.size() + qB.size()), 64'd0);
  endtask

  always @(negedge clk) begin : monitorA
    expT e;
    if (!rst && outValidA && outReady) begin
      if (qA.size() == 0) begin
        checkOutput("unexpected_outA_rd", {59'd0, outRdA}, 64'hFFFF);
      end else begin
        e = qA.pop_front();
        checkOutput("rsltA", {32'd0, outRsltA}, e.rslt);
        checkOutput("ltA", {63'd0, outLtA}, {63'd0, e.lt});
        checkOutput("rdA", {59'd0, outRdA}, {59'd0, e.rd});
      end
    end
  end

  always @(negedge clk) begin : monitorB
    expT e;
    if (!rst && outValidB && outReady) begin
      if (qB.size() == 0) begin
        checkOutput("unexpected_outB_rd", {59'd0, outRdB}, 64'hFFFF);
      end else begin
        e = qB.pop_front();
        checkOutput("rsltB", outRsltB, e.rslt);
        checkOutput("ltB", {63'd0, outLtB}, {63'd0, e.lt});
        checkOutput("rdB", {59'd0, outRdB}, {59'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; outReady = 1'b1;
    inValidA = 1'b0; inOpA = '0; inS1A = '0; inS2A = '0; inRdA = '0; inCmpuA = 1'b0;
    inValidB = 1'b0; inOpB = '0; inS1B = '0; inS2B = '0; inRdB = '0; inCmpuB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_in_readyA", {63'd0, inReadyA}, 64'd1);
    checkOutput("rst_out_validA", {63'd0, outValidA}, 64'd0);
    checkOutput("rst_ex_opA", {62'd0, exOpA}, 64'd0);
    checkOutput("rst_ex_s1A", {32'd0, exS1A}, 64'd0);
    checkOutput("rst_out_rsltA", {32'd0, outRsltA}, 64'd0);
    checkOutput("rst_out_ltA", {63'd0, outLtA}, 64'd0);
    checkOutput("rst_out_rdA", {59'd0, outRdA}, 64'd0);
    checkOutput("rst_in_readyB", {63'd0, inReadyB}, 64'd1);
    checkOutput("rst_ex_opB", {61'd0, exOpB}, 64'd0);
    @(posedge clk);
    #1;

    // Basic add with a latency probe: nothing after one edge, result after two.
    applyStimulus(0, 3'b001, 64'd5, 64'd7, 5'd3, 1'b0, 64'd12, 1'b0);
    @(negedge clk);
    checkOutput("latency_s1_only", {63'd0, outValidA}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_two", {63'd0, outValidA}, 64'd1);
    @(posedge clk);
    #1;

    applyStimulus(0, 3'b010, 64'hFFFF_FFFF, 64'd1, 5'd5, 1'b0, 64'hFFFF_FFFE, 1'b1);
    applyStimulus(0, 3'b010, 64'hFFFF_FFFF, 64'd1, 5'd6, 1'b1, 64'hFFFF_FFFE, 1'b0);
    applyStimulus(0, 3'b010, 64'd3, 64'd9, 5'd7, 1'b1, 64'hFFFF_FFFA, 1'b1);
    applyStimulus(0, 3'b010, 64'h8000_0000, 64'd1, 5'd8, 1'b1, 64'h7FFF_FFFF, 1'b0);
    applyStimulus(0, 3'b001, 64'hFFFF_FFFF, 64'd1, 5'd9, 1'b0, 64'h0, 1'b0);
    applyStimulus(1, 3'b101, 64'h7FFF_FFFF, 64'd1, 5'd10, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b1);
    applyStimulus(1, 3'b001, 64'h1_0000_0000, 64'd5, 5'd11, 1'b0, 64'h1_0000_0005, 1'b0);
    applyStimulus(1, 3'b010, 64'd0, 64'd1, 5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    waitDrain("drain_basic");

    // Backpressure: two accepts fill the pipe, then everything must hold until release.
    @(posedge clk);
    #1;
    outReady = 1'b0;
    fork
      begin
        applyStimulus(0, 3'b001, 64'd16, 64'd1, 5'd1, 1'b0, 64'd17, 1'b0);
        applyStimulus(0, 3'b001, 64'd32, 64'd1, 5'd2, 1'b0, 64'd33, 1'b0);
        applyStimulus(0, 3'b001, 64'd48, 64'd1, 5'd3, 1'b0, 64'd49, 1'b0);
        applyStimulus(0, 3'b001, 64'd64, 64'd1, 5'd4, 1'b0, 64'd65, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("bp_in_ready_low", {63'd0, inReadyA}, 64'd0);
          checkOutput("bp_out_valid_held", {63'd0, outValidA}, 64'd1);
          checkOutput("bp_out_rd_held", {59'd0, outRdA}, 64'd1);
          checkOutput("bp_ex_s1_held", {32'd0, exS1A}, 64'd32);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    waitDrain("drain_backpressure");

    // Flush with both stages full and a new request presented in the flush cycle.
    @(posedge clk);
    #1;
    outReady = 1'b0;
    applyStimulus(0, 3'b001, 64'd100, 64'd1, 5'd20, 1'b0, 64'd101, 1'b0);
    applyStimulus(0, 3'b001, 64'd200, 64'd1, 5'd21, 1'b0, 64'd201, 1'b0);
    inValidA = 1'b1; inOpA = 2'b01; inS1A = 32'd300; inS2A = 32'd1; inRdA = 5'd22; inCmpuA = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    inValidA = 1'b0;
    qA.delete();
    @(negedge clk);
    checkOutput("flush_out_valid", {63'd0, outValidA}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, inReadyA}, 64'd1);
    checkOutput("flush_ex_op", {62'd0, exOpA}, 64'd0);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 3'b001, 64'd2, 64'd2, 5'd13, 1'b0, 64'd4, 1'b0);
    waitDrain("drain_flush");

    // Reset mid-stream with both stages full.
    @(posedge clk);
    #1;
    outReady = 1'b0;
    applyStimulus(0, 3'b001, 64'd40, 64'd2, 5'd23, 1'b0, 64'd42, 1'b0);
    applyStimulus(0, 3'b001, 64'd50, 64'd2, 5'd24, 1'b0, 64'd52, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qA.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", {63'd0, outValidA}, 64'd0);
    checkOutput("midrst_ex_op", {62'd0, exOpA}, 64'd0);
    checkOutput("midrst_out_rslt", {32'd0, outRsltA}, 64'd0);
    checkOutput("midrst_out_rd", {59'd0, outRdA}, 64'd0);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    applyStimulus(0, 3'b010, 64'd10, 64'd4, 5'd14, 1'b0, 64'd6, 1'b0);
    waitDrain("drain_reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
